// File: rtl/display_arbiter.sv
// Round-robin arbiter that multiplexes three BCD sources onto one 4-digit display, with hold and blanking gap.
// Latency: req_i to gnt_o 1 cycle, to bcd_o 2 cycles from IDLE; re-arbitration only after HOLD_CYCLES.
// Backpressure: requests are ignored while a value is held; a granted requester is acknowledged by a one-cycle gnt_o.
module display_arbiter #(
    parameter int HOLD_CYCLES = 128,
    parameter int GAP_CYCLES  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req_i,
    input  logic [15:0] data0_i,
    input  logic [15:0] data1_i,
    input  logic [15:0] data2_i,
    output logic [2:0]  gnt_o,
    output logic [15:0] bcd_o,
    output logic        blank_o,
    output logic [1:0]  owner_o,
    output logic        err_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_GAP} state_t;

    localparam logic [15:0] HOLD_LD = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GAP_LD  = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
    localparam logic        GAP_EN  = (GAP_CYCLES > 0);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [1:0]  r_ptr, w_ptr_nxt;
    logic [1:0]  r_win, w_win_nxt;
    logic [2:0]  w_gnt_nxt;
    logic [15:0] w_bcd_nxt;
    logic [1:0]  w_owner_nxt;
    logic        w_blank_nxt, w_err_nxt;
    logic [1:0]  w_pick;
    logic [2:0]  w_sum;
    logic        w_any, w_sel, w_bad;
    logic [15:0] w_sample;

    function automatic logic has_bad_nibble(input logic [15:0] d);
        return (d[15:12] > 4'd9) || (d[11:8] > 4'd9) || (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
    endfunction

    // Scan from r_ptr upward; iterating downward lets the nearest requester win.
    always_comb begin
        w_pick = 2'd0;
        w_sum  = 3'd0;
        w_any  = |req_i;
        for (int k = 2; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + 3'(k);
            if (w_sum >= 3'd3) w_sum = w_sum - 3'd3;
            if (req_i[w_sum[1:0]]) w_pick = w_sum[1:0];
        end
    end

    always_comb begin
        case (r_win)
            2'd1:    w_sample = data1_i;
            2'd2:    w_sample = data2_i;
            default: w_sample = data0_i;
        endcase
        w_bad = has_bad_nibble(w_sample);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_ptr   <= 2'd0;
            r_win   <= 2'd0;
            gnt_o   <= 3'b000;
            bcd_o   <= 16'h0000;
            blank_o <= 1'b0;
            owner_o <= 2'd3;
            err_o   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_win   <= w_win_nxt;
            gnt_o   <= w_gnt_nxt;
            bcd_o   <= w_bcd_nxt;
            blank_o <= w_blank_nxt;
            owner_o <= w_owner_nxt;
            err_o   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_any) w_state_nxt = S_LOAD;
            S_LOAD: w_state_nxt = w_bad ? S_IDLE : S_HOLD;
            S_HOLD: begin
                if (r_cnt == 16'd0) begin
                    if (!w_any)                             w_state_nxt = S_IDLE;
                    else if (GAP_EN && (w_pick != owner_o)) w_state_nxt = S_GAP;
                    else                                    w_state_nxt = S_LOAD;
                end
            end
            S_GAP:  if (r_cnt == 16'd0) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The winner and pointer are committed at selection, so a GAP never re-arbitrates.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_win_nxt   = r_win;
        w_gnt_nxt   = 3'b000;
        w_bcd_nxt   = bcd_o;
        w_owner_nxt = owner_o;
        w_err_nxt   = 1'b0;
        w_sel       = ((r_state == S_IDLE) || ((r_state == S_HOLD) && (r_cnt == 16'd0))) && w_any;
        if (w_sel) begin
            w_win_nxt = w_pick;
            w_ptr_nxt = (w_pick == 2'd2) ? 2'd0 : w_pick + 2'd1;
        end
        if (w_state_nxt == S_LOAD) w_gnt_nxt = 3'b001 << w_win_nxt;
        w_blank_nxt = (w_state_nxt == S_GAP);
        case (r_state)
            S_LOAD: begin
                if (w_bad) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_bcd_nxt   = w_sample;
                    w_owner_nxt = r_win;
                    w_cnt_nxt   = HOLD_LD;
                end
            end
            S_HOLD: begin
                if (r_cnt != 16'd0)             w_cnt_nxt = r_cnt - 16'd1;
                else if (w_state_nxt == S_GAP)  w_cnt_nxt = GAP_LD;
            end
            S_GAP:  if (r_cnt != 16'd0) w_cnt_nxt = r_cnt - 16'd1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed cycle-by-cycle bench for display_arbiter with HOLD_CYCLES=4, GAP_CYCLES=2.
module tb_display_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_i = 3'b000;
    logic [15:0] data0_i = 16'h0000, data1_i = 16'h0000, data2_i = 16'h0000;
    logic [2:0]  gnt_o;
    logic [15:0] bcd_o;
    logic        blank_o;
    logic [1:0]  owner_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [15:0] d0, d1, d2;
        logic [2:0]  gnt;
        logic [15:0] bcd;
        logic        blank;
        logic [1:0]  owner;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    display_arbiter #(.HOLD_CYCLES(4), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i),
        .data0_i(data0_i), .data1_i(data1_i), .data2_i(data2_i),
        .gnt_o(gnt_o), .bcd_o(bcd_o), .blank_o(blank_o), .owner_o(owner_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic [2:0] req,
                                input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                                input logic [2:0] gnt, input logic [15:0] bcd,
                                input logic blank, input logic [1:0] owner, input logic err);
        vec_t v;
        v.rst = rst; v.req = req; v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.gnt = gnt; v.bcd = bcd; v.blank = blank; v.owner = owner; v.err = err;
        return v;
    endfunction

    task automatic push(input int n, input vec_t v);
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, got, exp);
        end
    endtask

    task automatic chk_outs(input int idx, input vec_t v);
        chk("gnt",   idx, 16'(gnt_o),   16'(v.gnt));
        chk("bcd",   idx, bcd_o,        v.bcd);
        chk("blank", idx, 16'(blank_o), 16'(v.blank));
        chk("owner", idx, 16'(owner_o), 16'(v.owner));
        chk("err",   idx, 16'(err_o),   16'(v.err));
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        rst_n = v.rst; req_i = v.req;
        data0_i = v.d0; data1_i = v.d1; data2_i = v.d2;
        @(posedge clk);
        #1;
        chk_outs(idx, v);
    endtask

    localparam logic [15:0] A = 16'h1234, B = 16'h4321, C = 16'h5678, D = 16'h9999, X = 16'h12A4;

    initial begin
        // Single requester, re-request without gap, then drop to IDLE.
        push(1, mk(1, 3'b001, A, 0, 0, 3'b001, 16'h0000, 0, 3, 0));
        push(1, mk(1, 3'b001, A, 0, 0, 3'b000, A, 0, 0, 0));
        push(3, mk(1, 3'b001, B, 0, 0, 3'b000, A, 0, 0, 0));
        push(1, mk(1, 3'b001, B, 0, 0, 3'b001, A, 0, 0, 0));
        push(6, mk(1, 3'b000, B, 0, 0, 3'b000, B, 0, 0, 0));
        // Invalid BCD from requester 1.
        push(1, mk(1, 3'b010, B, X, 0, 3'b010, B, 0, 0, 0));
        push(1, mk(1, 3'b000, B, X, 0, 3'b000, B, 0, 0, 1));
        push(2, mk(1, 3'b000, B, X, 0, 3'b000, B, 0, 0, 0));
        // Synchronous-looking reset through the vector stream.
        push(2, mk(0, 3'b000, A, C, D, 3'b000, 16'h0000, 0, 3, 0));
        // All three requesting: 001, 010, 100 with 2-cycle blanking between values.
        push(1, mk(1, 3'b111, A, C, D, 3'b001, 16'h0000, 0, 3, 0));
        push(4, mk(1, 3'b111, A, C, D, 3'b000, A, 0, 0, 0));
        push(2, mk(1, 3'b111, A, C, D, 3'b000, A, 1, 0, 0));
        push(1, mk(1, 3'b111, A, C, D, 3'b010, A, 0, 0, 0));
        push(4, mk(1, 3'b111, A, C, D, 3'b000, C, 0, 1, 0));
        push(2, mk(1, 3'b111, A, C, D, 3'b000, C, 1, 1, 0));
        push(1, mk(1, 3'b111, A, C, D, 3'b100, C, 0, 1, 0));
        push(1, mk(1, 3'b111, A, C, D, 3'b000, D, 0, 2, 0));
        // Requests drop during the 9999 hold: value stays, no grants.
        push(8, mk(1, 3'b000, A, C, D, 3'b000, D, 0, 2, 0));
        // Fresh request wraps round-robin back to requester 0.
        push(1, mk(1, 3'b111, A, C, D, 3'b001, D, 0, 2, 0));
        push(4, mk(1, 3'b111, A, C, D, 3'b000, A, 0, 0, 0));
        push(1, mk(1, 3'b111, A, C, D, 3'b000, A, 1, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        chk_outs(-1, mk(0, 3'b000, 0, 0, 0, 3'b000, 16'h0000, 0, 3, 0));

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // Second GAP cycle, then asynchronous reset mid-cycle.
        run_vec(100, mk(1, 3'b111, A, C, D, 3'b000, A, 1, 0, 0));
        #2;
        rst_n = 1'b0; req_i = 3'b000;
        #1;
        chk_outs(101, mk(0, 3'b000, A, C, D, 3'b000, 16'h0000, 0, 3, 0));
        run_vec(102, mk(0, 3'b000, A, C, D, 3'b000, 16'h0000, 0, 3, 0));
        for (int i = 0; i < 3; i++)
            run_vec(103 + i, mk(1, 3'b000, A, C, D, 3'b000, 16'h0000, 0, 3, 0));

        // Grant committed at GAP entry survives the winner dropping its request.
        run_vec(110, mk(1, 3'b100, A, C, D, 3'b100, 16'h0000, 0, 3, 0));
        for (int i = 0; i < 4; i++)
            run_vec(111 + i, mk(1, 3'b100, A, C, D, 3'b000, D, 0, 2, 0));
        run_vec(115, mk(1, 3'b001, A, C, D, 3'b000, D, 1, 2, 0));
        run_vec(116, mk(1, 3'b000, A, C, D, 3'b000, D, 1, 2, 0));
        run_vec(117, mk(1, 3'b000, A, C, D, 3'b001, D, 0, 2, 0));
        run_vec(118, mk(1, 3'b000, A, C, D, 3'b000, A, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 128: clk cycles a granted value stays on display before re-arbitration; legal range 1..65535.
REQ-002 SHALL have parameter GAP_CYCLES, default 16: clk cycles of blanking between two different granted values; 0 disables the gap.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_i  input  3: per-requester display request; bit k belongs to requester k.
REQ-006 SHALL have ports data0_i, data1_i, data2_i  input  16 each: four packed BCD digits per requester, [15:12] most significant.
REQ-007 SHALL have port gnt_o  output  3: one-hot, single-cycle grant; requester samples it as acknowledge.
REQ-008 SHALL have port bcd_o  output  16: value for the 4-digit seven-segment display driver's bcd_in.
REQ-009 SHALL have port blank_o  output  1: high while the display is to be blanked.
REQ-010 SHALL have port owner_o  output  2: index of requester whose value is on bcd_o; 2'd3 = none since reset.
REQ-011 SHALL have port err_o  output  1: single-cycle pulse when a granted value contains a nibble > 9.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, HOLD, GAP; all outputs registered.
REQ-013 IDLE: when req_i != 0, SHALL select a winner and enter LOAD next cycle; bcd_o and owner_o retain previous values, blank_o = 0.
REQ-014 Winner selection SHALL be round-robin: search order starts at (last winner + 1) mod 3; after reset search starts at requester 0.
REQ-015 LOAD lasts exactly 1 cycle; gnt_o SHALL be high for the winner only during LOAD; data of the winner is sampled at the end of LOAD.
REQ-016 Requester SHALL hold data stable while req is high until gnt; req still high after gnt counts as a new request.
REQ-017 Valid sample: bcd_o <= sample, owner_o <= winner, blank_o <= 0 on the edge ending LOAD; enter HOLD with counter loaded to HOLD_CYCLES-1 (latency req -> bcd_o = 2 cycles from IDLE).
REQ-018 Invalid sample (any nibble > 9): err_o pulses 1 cycle after LOAD, bcd_o/owner_o unchanged, round-robin pointer still advances past the winner, next state IDLE.
REQ-019 HOLD: counter decrements each cycle; new requests are ignored until counter = 0.
REQ-020 At counter = 0: no request -> IDLE (value stays displayed); request from a requester other than owner with GAP_CYCLES > 0 -> GAP; otherwise -> LOAD directly.
REQ-021 GAP: blank_o = 1 for exactly GAP_CYCLES cycles, bcd_o unchanged, then LOAD; winner is chosen on GAP entry and is not re-evaluated.
REQ-022 Winner dropping req before its LOAD SHALL still be granted (grant is committed at selection).
REQ-023 Simultaneous requests SHALL never produce more than one gnt_o bit in any cycle.
REQ-024 Counter width SHALL be 16 bits; no wrap occurs within legal parameter range.

Reset
REQ-025 On rst_n low, immediately and asynchronously: state IDLE, gnt_o = 0, bcd_o = 16'h0000, blank_o = 0, owner_o = 2'd3, err_o = 0, counter = 0, round-robin pointer = 0.
REQ-026 Reset asserted mid-HOLD, mid-GAP or during LOAD SHALL abandon the operation; no grant pulse occurs after deassertion until a fresh arbitration.
REQ-027 First arbitration after reset release SHALL occur on the first rising edge with rst_n high.

Verification (HOLD_CYCLES=4, GAP_CYCLES=2)
REQ-028 req_i=3'b001, data0_i=16'h1234 from IDLE -> gnt_o=001 next cycle, bcd_o=16'h1234 and owner_o=0 one cycle later, blank_o stays 0.
REQ-029 req_i=3'b111 held constantly, data 16'h1234/16'h5678/16'h9999 -> grants 001,010,100,001 in order; each value shown 4 cycles, then blank_o high 2 cycles before the next.
REQ-030 req_i=3'b010 with data1_i=16'h12A4 -> one gnt_o=010, err_o pulse, bcd_o keeps prior value, FSM returns IDLE.
REQ-031 Requester 0 alone re-requests at end of HOLD -> LOAD with no GAP, blank_o never asserted, bcd_o updates to new data0_i.
REQ-032 rst_n driven low 2 cycles into GAP -> blank_o=0, bcd_o=16'h0000, owner_o=3 immediately, no gnt_o pulse until a req after release.
REQ-033 All req low after HOLD with 16'h9999 displayed -> FSM IDLE, bcd_o stays 16'h9999 indefinitely, gnt_o stays 0.
